// File: rtl/result_serializer.sv
// Captures six datapath result words in one cycle and streams them out one per beat
// with index/last tags. Define RESULT_PARITY_EN to add the out_parity output.
module result_serializer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] result1,
    input  logic [DATA_W-1:0] result2,
    input  logic [DATA_W-1:0] result3,
    input  logic [DATA_W-1:0] result4,
    input  logic [DATA_W-1:0] result5,
    input  logic [DATA_W-1:0] result6,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_idx,
    output logic              out_last,
`ifdef RESULT_PARITY_EN
    output logic              out_parity,
`endif
    output logic [CNT_W-1:0]  frame_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [2:0]       LAST_IDX = 3'd5;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] buf_q [6];
    logic [DATA_W-1:0] buf_d [6];

    logic beat;
    logic last_beat;
    logic capture;

    assign beat      = (state_q == SEND) && out_ready;
    assign last_beat = beat && (idx_q == LAST_IDX);
    // Accepting a new set on the final beat is what gives bubble-free back-to-back frames.
    assign in_ready  = (state_q == IDLE) || last_beat;
    assign capture   = in_valid && in_ready;

    // NOTE: every next-state signal gets a default before any branch, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;

        if (capture) begin
            buf_d[0] = result1;
            buf_d[1] = result2;
            buf_d[2] = result3;
            buf_d[3] = result4;
            buf_d[4] = result5;
            buf_d[5] = result6;
        end

        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = SEND;
                    idx_d   = 3'd0;
                end
            end
            SEND: begin
                if (beat) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        idx_d = 3'd0;
                        if (!in_valid) begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the capture buffer is reset too, because out_data must read 0 straight out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            for (int i = 0; i < 6; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        case (idx_q)
            3'd0:    out_data = buf_q[0];
            3'd1:    out_data = buf_q[1];
            3'd2:    out_data = buf_q[2];
            3'd3:    out_data = buf_q[3];
            3'd4:    out_data = buf_q[4];
            3'd5:    out_data = buf_q[5];
            default: out_data = '0;
        endcase
    end

    assign out_valid = (state_q == SEND);
    assign out_idx   = idx_q;
    assign out_last  = out_valid && (idx_q == LAST_IDX);
    assign frame_cnt = cnt_q;

`ifdef RESULT_PARITY_EN
    assign out_parity = ^out_data;
`endif

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer: a per-cycle vector table for the basic frame and
// backpressure, then hand-written back-to-back, mid-frame reset, counter-wrap and parity runs.
module tb_result_serializer;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] res [6];
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [2:0]    out_idx;
    logic          out_last;
    logic [CW-1:0] frame_cnt;
`ifdef RESULT_PARITY_EN
    logic          out_parity;
`endif

    int tests  = 0;
    int failed = 0;

    result_serializer #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result1   (res[0]),
        .result2   (res[1]),
        .result3   (res[2]),
        .result4   (res[3]),
        .result5   (res[4]),
        .result6   (res[5]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
`ifdef RESULT_PARITY_EN
        .out_parity(out_parity),
`endif
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          rst_n;
        logic          in_valid;
        logic          out_ready;
        logic [DW-1:0] base;
        logic          chk_data;
        logic          exp_ov;
        logic          exp_ir;
        logic [DW-1:0] exp_data;
        logic [2:0]    exp_idx;
        logic          exp_last;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_res(input logic [DW-1:0] base);
        for (int i = 0; i < 6; i++) res[i] = base + DW'(i);
    endtask

    task automatic add(input logic r, input logic iv, input logic ordy, input logic [DW-1:0] base,
                       input logic chk, input logic ov, input logic ir, input logic [DW-1:0] data,
                       input logic [2:0] idx, input logic last, input logic [CW-1:0] cnt);
        vec_t v;
        v.rst_n = r; v.in_valid = iv; v.out_ready = ordy; v.base = base;
        v.chk_data = chk; v.exp_ov = ov; v.exp_ir = ir; v.exp_data = data;
        v.exp_idx = idx; v.exp_last = last; v.exp_cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses in_valid for one cycle and drains with out_ready high, bounded by a cycle budget.
    task automatic send_frame(input logic [DW-1:0] base);
        bit done;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        set_res(base);
        tick();
        in_valid = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (out_valid && out_last) done = 1'b1;
            tick();
        end
        check("frame_drained", 32'(done), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_res('0);
        tick();
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready",  32'(in_ready),  32'd1);
        check("reset out_data",  out_data,       32'd0);
        check("reset out_idx",   32'(out_idx),   32'd0);
        check("reset out_last",  32'(out_last),  32'd0);
        check("reset frame_cnt", 32'(frame_cnt), 32'd0);

        // Single frame 1..6: capture, then six beats with out_ready high.
        add(1, 1, 1, 32'h1, 1, 0, 1, 32'h0, 3'd0, 0, 4'd0);
        for (int w = 0; w < 6; w++)
            add(1, 0, 1, 32'h77, 1, 1, (w == 5), DW'(w + 1), 3'(w), (w == 5), 4'd0);
        // Back in IDLE with one frame counted; this row also captures the backpressure frame.
        add(1, 1, 1, 32'h1, 0, 0, 1, 32'h0, 3'd0, 0, 4'd1);
        add(1, 0, 1, 32'h77, 1, 1, 0, 32'h1, 3'd0, 0, 4'd1);
        add(1, 0, 1, 32'h77, 1, 1, 0, 32'h2, 3'd1, 0, 4'd1);
        // Four stalled cycles on word 3 while new input data is offered and must be ignored.
        for (int s = 0; s < 4; s++)
            add(1, 1, 0, 32'h50, 1, 1, 0, 32'h3, 3'd2, 0, 4'd1);
        add(1, 0, 1, 32'h77, 1, 1, 0, 32'h3, 3'd2, 0, 4'd1);
        add(1, 0, 1, 32'h77, 1, 1, 0, 32'h4, 3'd3, 0, 4'd1);
        add(1, 0, 1, 32'h77, 1, 1, 0, 32'h5, 3'd4, 0, 4'd1);
        add(1, 0, 1, 32'h77, 1, 1, 1, 32'h6, 3'd5, 1, 4'd1);
        add(1, 0, 1, 32'h0, 0, 0, 1, 32'h0, 3'd0, 0, 4'd2);

        for (int k = 0; k < vecs.size(); k++) begin
            vec_t v;
            v = vecs[k];
            rst_n     = v.rst_n;
            in_valid  = v.in_valid;
            out_ready = v.out_ready;
            set_res(v.base);
            #1;
            check($sformatf("row%0d out_valid", k), 32'(out_valid), 32'(v.exp_ov));
            check($sformatf("row%0d in_ready", k),  32'(in_ready),  32'(v.exp_ir));
            check($sformatf("row%0d frame_cnt", k), 32'(frame_cnt), 32'(v.exp_cnt));
            if (v.chk_data) begin
                check($sformatf("row%0d out_data", k), out_data,      v.exp_data);
                check($sformatf("row%0d out_idx", k),  32'(out_idx),  32'(v.exp_idx));
                check($sformatf("row%0d out_last", k), 32'(out_last), 32'(v.exp_last));
            end
            tick();
        end

        // Back-to-back: frame A captured, frame B held on the inputs and taken on A's last beat.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        set_res(32'hA0);
        #1;
        check("b2b idle in_ready", 32'(in_ready), 32'd1);
        tick();
        set_res(32'hB0);
        for (int k = 0; k < 12; k++) begin
            if (k == 11) in_valid = 1'b0;
            #1;
            check($sformatf("b2b%0d out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("b2b%0d out_data", k), out_data,
                  (k < 6) ? 32'hA0 + 32'(k) : 32'hB0 + 32'(k - 6));
            check($sformatf("b2b%0d out_idx", k), 32'(out_idx), 32'(k % 6));
            if (k == 5) check("b2b A-last in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        check("b2b end out_valid", 32'(out_valid), 32'd0);
        check("b2b frame_cnt",     32'(frame_cnt), 32'd4);

        // Reset after three beats: frame abandoned, counter cleared, reset beats the handshake.
        in_valid = 1'b1;
        set_res(32'h20);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("mid%0d out_data", k), out_data, 32'h20 + 32'(k));
            tick();
        end
        rst_n    = 1'b0;
        in_valid = 1'b1;
        set_res(32'h60);
        tick();
        rst_n    = 1'b0;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        check("mid rst frame_cnt", 32'(frame_cnt), 32'd0);
        check("mid rst in_ready",  32'(in_ready),  32'd1);
        check("mid rst out_data",  out_data,       32'd0);
        check("mid rst out_idx",   32'(out_idx),   32'd0);
        in_valid = 1'b1;
        set_res(32'h30);
        tick();
        in_valid = 1'b0;
        #1;
        check("post rst out_valid", 32'(out_valid), 32'd1);
        check("post rst out_idx",   32'(out_idx),   32'd0);
        check("post rst out_data",  out_data,       32'h30);

        // Clear the counter again, then drain 17 frames through the 4-bit counter.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int f = 0; f < 17; f++) begin
            send_frame(32'(f) << 4);
            if (f == 15) check("wrap after 16", 32'(frame_cnt), 32'd0);
        end
        check("wrap after 17", 32'(frame_cnt), 32'd1);

`ifdef RESULT_PARITY_EN
        res[0] = 32'h7;
        res[1] = 32'h3;
        for (int i = 2; i < 6; i++) res[i] = '0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        #1;
        check("parity beat0 data", out_data,         32'h7);
        check("parity beat0",      32'(out_parity),  32'd1);
        out_ready = 1'b1;
        tick();
        check("parity beat1 data", out_data,         32'h3);
        check("parity beat1",      32'(out_parity),  32'd0);
        for (int c = 0; c < 10 && out_valid; c++) tick();
        check("parity drained", 32'(out_valid), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/result_serializer.md
# result_serializer

Drain-side companion to the six-output arithmetic datapath (`result1`..`result6`). It captures one full result set in a single cycle, then streams the six words out one per beat on a valid/ready interface, tagged with index and last flag. It sits between the combinational expression block and any narrow 32-bit consumer such as a bus bridge, FIFO or checker. It also maintains a count of completed frames.

## Interface
- `DATA_W`, default 32: width of each result word and of `out_data`.
- `CNT_W`, default 16: width of the completed-frame counter.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid` input 1: the result set on `result1`..`result6` is valid.
- `in_ready` output 1: the block can capture a result set this cycle.
- `result1`..`result6` input DATA_W each: result words from the datapath.
- `out_valid` output 1: `out_data` holds a valid word.
- `out_ready` input 1: the downstream consumer accepts the word.
- `out_data` output DATA_W: current word.
- `out_idx` output 3: word index, 0..5, where 0 corresponds to `result1`.
- `out_last` output 1: high when `out_idx`==5.
- `frame_cnt` output CNT_W: number of fully drained frames.
- `out_parity` output 1: present only with `RESULT_PARITY_EN`.

## Operation
- Registers:
  - Six DATA_W capture registers `buf[0..5]`.
  - A 3-bit `idx`.
  - A state register with states IDLE and SEND.
  - `frame_cnt`.
- Handshakes:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output beat occurs when `out_valid && out_ready`.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On an input transfer: load `buf[i]` with `result(i+1)`, set `idx`=0, go to SEND.
- SEND:
  - `out_valid`=1, `out_data`=`buf[idx]`, `out_idx`=`idx`.
  - On a beat with `idx`<5: increment `idx`.
  - On a beat with `idx`==5:
    - Increment `frame_cnt`.
    - If `in_valid`=1 in the same cycle, recapture, set `idx`=0 and stay in SEND. This gives back-to-back frames with no bubble.
    - Otherwise go to IDLE.
- `in_ready` in SEND equals `out_ready && idx==5`, combinational from `out_ready`. Results are never overwritten mid-frame.
- `out_valid` stays high and `out_data`, `out_idx` stay stable until the beat completes. Backpressure of any length is legal.
- `frame_cnt` wraps from 2^CNT_W−1 to 0 with no flag.
- `idx` never exceeds 5. Values 6 and 7 are unreachable.
- Result inputs are sampled only on an input transfer. Changes at any other time are ignored.

## Timing
- Reset values, forced by `rst_n`=0 at a rising edge:
  - State = IDLE.
  - `idx`=0.
  - `frame_cnt`=0.
  - `buf`=0.
  - `out_valid`=0, `in_ready`=1, `out_data`=0, `out_idx`=0, `out_last`=0, `out_parity`=0.
- Reset mid-frame abandons the frame. Remaining words are never emitted and `frame_cnt` does not increment.
- Reset has priority over any simultaneous handshake.
- Latency: the input transfer happens at edge N. `out_valid`=1 with word 0 from edge N+1.
- Minimum frame duration is 6 cycles. Sustained throughput is one word per cycle with `out_ready` held high.
- `frame_cnt` updates on the same edge as the last beat.

## Configuration
- `RESULT_PARITY_EN`:
  - Defined: adds the `out_parity` output, equal to the XOR-reduction of `out_data`. It is combinational from the selected buffer word and valid whenever `out_valid`=1.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- **Reset then single frame:** present results 1,2,3,4,5,6 with `in_valid` pulsed for one cycle and `out_ready`=1.
  - `out_data` is 1..6 on 6 consecutive cycles, `out_idx` 0..5, `out_last` only on the word 6 beat.
  - `frame_cnt`=1 and state returns to IDLE (`in_ready`=1).
- **Backpressure:** hold `out_ready`=0 for 4 cycles while `idx`=2 (word 0x3).
  - `out_data` stays 0x3 and `out_idx` stays 2.
  - Input changes are ignored and `in_ready`=0 throughout.
- **Back-to-back:** send frame A (0xA0..0xA5), then hold `in_valid`=1 with frame B (0xB0..0xB5).
  - Frame B is captured on A's last beat.
  - The stream is 12 consecutive words with no gap and `frame_cnt`=2.
- **Reset mid-frame:** apply `rst_n`=0 for one cycle after 3 beats.
  - `out_valid`=0 and `frame_cnt`=0.
  - The next frame starts at `idx` 0.
- **Counter wrap:** with `CNT_W`=4, drain 17 frames.
  - `frame_cnt` reads 1 after the 17th frame.
- **Parity:** with `RESULT_PARITY_EN` defined, send a frame whose word 0 is 0x00000007 and word 1 is 0x00000003.
  - `out_parity` is 1 on beat 0 and 0 on beat 1.
